// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing (pixel tick, syncs, x/y, video_on) from the system clock.
// Define VGA_FRAME_CNT_EN to enable the frame_start pulse and the 16-bit frame counter.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic        p_tick,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    // Syncs decode the next counter values so the registered pins line up with x/y.
    hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
  end

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked block;
  // all sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign p_tick   = tick;
  assign x        = x_q;
  assign y        = y_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (x_q < X_VIS) && (y_q < Y_VIS);

`ifdef VGA_FRAME_CNT_EN
  logic        frame_end;
  logic        frame_start_q;
  logic [15:0] frame_cnt_q;

  // Last pixel of the last line: the next tick wraps to (0,0).
  assign frame_end = tick && (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= frame_end;
      if (frame_end) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
`else
  assign frame_start = 1'b0;
  assign frame_cnt   = '0;
`endif

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Generates 640x480@60 Hz VGA timing from the 100 MHz board clock: pixel-rate tick, active-low hsync/vsync, current pixel coordinates and the active-video flag.
- Drives the `x`, `y`, `video_on` inputs of the text/pixel renderers and the sync pins of the VGA connector.
- Single pixel-tick domain derived by clock enable; no clock generation.

## Interface
Parameters:
- CLK_DIV, 4, system clocks per pixel (power of two, ≥2)
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- p_tick  out  1  one-clk pulse once per pixel period
- x  out  10  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- video_on  out  1  high while x<H_DISPLAY and y<V_DISPLAY
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- frame_start  out  1  one-clk pulse on wrap to (0,0)
- frame_cnt  out  16  frames completed since reset

## Operation
- Totals:
  - H_TOTAL = sum of the four H_* parameters = 800.
  - V_TOTAL = sum of the four V_* parameters = 525.
- Divider:
  - div counts 0..CLK_DIV-1 every clk and wraps.
  - p_tick = (div == CLK_DIV-1), combinational from registered div.
- Counters: on a clk edge with p_tick=1:
  - x increments.
  - At x = H_TOTAL-1, x wraps to 0 and y increments.
  - At y = V_TOTAL-1 together with that wrap, y wraps to 0.
  - Without p_tick, x and y hold.
- hsync, vsync:
  - Registered, decoded from the next values of x and y so they align with the x/y they describe.
  - hsync = 0 iff x ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
  - vsync = 0 iff y ∈ [490,491].
- video_on: combinational from registered x and y.
- frame_start:
  - Registered; high for exactly one clk, in the cycle when x and y both first read 0 after a wrap from (799,524).
  - Not asserted by reset.
- Reset values: div=0, x=0, y=0, hsync=1, vsync=1, frame_start=0, frame_cnt=0; p_tick=0 and video_on=1 as a consequence.
- Reset mid-frame: all state returns to reset values on the same edge; the next frame restarts at (0,0) without a sync glitch. hsync/vsync go high immediately.

## Timing
- After rst deasserts (first non-reset edge = cycle 0), p_tick is first high in cycle CLK_DIV-1 = 3; x reads 1 from cycle 4.
- One line = 800×4 = 3200 clks; one frame = 525×3200 = 1,680,000 clks, giving 59.52 Hz.
- Latency: x, y, hsync and vsync change on the same edge. video_on follows x/y with zero cycles.
- hsync low for 96×4 = 384 clks per line; vsync low for 2 lines = 6400 clks.

## Configuration
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - frame_cnt increments by 1 on each frame_start, wrapping 0xFFFF→0x0000.
  - frame_start is live.
- Undefined:
  - frame_cnt is tied to 16'h0000 and frame_start to 0.
  - No counter flops are synthesized.
  - Sync timing is identical.

## Test plan
- Reset hold 5 clks, then release → x=0, y=0, hsync=1, vsync=1, video_on=1; first p_tick in cycle 3; x=1 in cycle 4.
- Run one line → x steps 0..799 and wraps to 0 with y=1.
  - hsync falls when x becomes 656 and rises when x becomes 752: low for 384 clks.
  - video_on falls when x becomes 640.
- Run one frame → vsync low exactly while y∈{490,491}.
  - video_on=0 for all y≥480.
  - Frame period is 1,680,000 clks.
- With VGA_FRAME_CNT_EN, run 3 frames → frame_start pulses 3 times (1 clk each, at x=y=0); frame_cnt=3. Without the macro, frame_cnt stays 0 throughout.
- Assert rst for 1 clk at x=700, y=491 (hsync=0, vsync=0) → next edge: x=0, y=0, hsync=1, vsync=1, frame_cnt=0.
- Check every cycle that p_tick is a 1-of-4 pulse and that x/y never exceed 799/524.
